mult_word_io: RTL and testbench
===============================

# mult_word_io

Word-serial front/back end for the Karatsuba multiplier accelerator. Accepts operand A then operand B as WordWidth-bit words over a valid/ready stream and assembles them into the wide operand buses. Pulses the accelerator's start, waits for its done pulse, captures the 2·BufferLength-bit product, and streams it out word-by-word over a second valid/ready stream. Sits between the system bus adapter and the accelerator top level.

## Interface
- BufferLength, 132, accelerator buffer width; product is 2·BufferLength bits
- InputALength, 131, operand A width
- InputBLength, 127, operand B width
- WordWidth, 32, stream word width
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock; asynchronous, active-low
- in_valid_i  in  1  input word valid
- in_data_i  in  WordWidth  input word, LSW first, A words then B words
- in_ready_o  out  1  input word accepted when valid&&ready
- acc_inputA_o  out  InputALength  assembled operand A to accelerator
- acc_inputB_o  out  InputBLength  assembled operand B to accelerator
- acc_start_o  out  1  one-cycle start pulse to accelerator
- acc_done_i  in  1  accelerator done pulse
- acc_outputM_i  in  2·BufferLength  accelerator product
- out_valid_o  out  1  output word valid
- out_data_o  out  WordWidth  product word, LSW first
- out_last_o  out  1  marks final product word
- out_ready_i  in  1  downstream accepts when valid&&ready
- busy_o  out  1  high in any state other than LOAD_A with zero words loaded

## Operation
- Word counts: NA = ceil(InputALength/WordWidth) = 5; NB = ceil(InputBLength/WordWidth) = 4; NM = ceil(2·BufferLength/WordWidth) = 9.
- States: LOAD_A → LOAD_B → START → WAIT → UNLOAD → LOAD_A.
- LOAD_A: in_ready_o=1; word k written to A[k·W +: W]; bits above InputALength-1 in word NA-1 discarded. After word NA-1 accepted → LOAD_B, word counter cleared.
- LOAD_B: same for B with NB words and InputBLength truncation. After word NB-1 accepted → START.
- START: acc_start_o=1 for exactly this cycle; → WAIT.
- WAIT: in_ready_o=0; when acc_done_i=1, acc_outputM_i captured into result register; → UNLOAD.
- UNLOAD: out_valid_o=1; out_data_o = result[j·W +: W], upper bits of word NM-1 zero-filled beyond 2·BufferLength; out_last_o=1 when j=NM-1. j advances only on out_valid_o&&out_ready_i. Handshake on last word → LOAD_A.
- acc_inputA_o/acc_inputB_o driven from operand registers; stable from START through end of UNLOAD; not cleared between operations (overwritten word-by-word by next load).
- acc_done_i outside WAIT ignored, no state or register change.
- in_valid_i outside LOAD_A/LOAD_B ignored (in_ready_o=0).
- out_data_o/out_last_o hold stable while out_valid_o&&!out_ready_i.

## Timing
- Reset (async assert, any state, including mid-WAIT/UNLOAD): state=LOAD_A, counters=0, operand and result registers=0, in_ready_o=1 after reset release, acc_start_o=0, out_valid_o=0, out_last_o=0, out_data_o=0, busy_o=0.
- All outputs registered or decoded from registered state; no combinational in→out paths except none (in_ready_o from state only, not from in_valid_i).
- One word accepted per cycle; last B word accepted at edge N → acc_start_o high in cycle N+1 → WAIT from N+2.
- done sampled at edge D → out_valid_o high from cycle D+1 with word 0.
- Full-rate output: NM words in NM cycles when out_ready_i tied high.
- After last output handshake at edge L, in_ready_o=1 in cycle L+1 (back-to-back operations allowed).
- Minimum load-to-start latency: NA+NB+1 cycles.

## Structure
- Package mult_io_pkg: state enum, localparams NA, NB, NM, counter width $clog2(max(NA,NB,NM)).
- One natural sub-module: word_packer (parameterized width/word count; writes indexed word into wide register with truncation); instantiated for A and B. Output word mux kept inline.

## Test plan
- A=1, B=1 (words 1,0,0,0,0 / 1,0,0,0); model done 10 cycles after start with outputM=1 → out words 1,0×8, out_last_o on word 8, acc_start_o exactly one cycle.
- A word 4=0xFFFFFFFF, others 0 → acc_inputA_o[130:128]=3'b111, rest zero; B word 3=0xFFFFFFFF → acc_inputB_o[126:96] all ones.
- outputM=2^256 with out_ready_i toggling 1,0,0,1… → word 8=0x00000001, words 0–7 zero, data stable during stalls, exactly 9 handshakes.
- Spurious acc_done_i during LOAD_B and UNLOAD → no state change, no capture, no extra output word.
- Assert rst_ni low during WAIT, then during UNLOAD word 4 → all outputs at reset values immediately; next full operation completes correctly.
- Two back-to-back operations with in_valid_i held high → second load begins cycle after first out_last_o handshake; second product correct.

Source files
------------

// File: rtl/mult_io_pkg.sv
// Shared constants, state encoding and sizing helpers for the word-serial
// front/back end of the Karatsuba multiplier accelerator.
package mult_io_pkg;

  localparam int BUFFER_LENGTH  = 132;
  localparam int INPUT_A_LENGTH = 131;
  localparam int INPUT_B_LENGTH = 127;
  localparam int WORD_WIDTH     = 32;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  localparam int NA    = ceil_div(INPUT_A_LENGTH, WORD_WIDTH);
  localparam int NB    = ceil_div(INPUT_B_LENGTH, WORD_WIDTH);
  localparam int NM    = ceil_div(2 * BUFFER_LENGTH, WORD_WIDTH);
  localparam int CNT_W = cnt_width(NA, NB, NM);

  typedef enum logic [2:0] {
    ST_LOAD_A = 3'd0,
    ST_LOAD_B = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_UNLOAD = 3'd4
  } state_t;

endpackage

// File: rtl/word_packer.sv
// Assembles a wide operand register from indexed stream words; bits of the
// top word that fall beyond the operand width are simply never stored.
module word_packer #(
  parameter int Width     = 131,
  parameter int WordWidth = 32,
  parameter int CntW      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [CntW-1:0]      idx,
  input  logic [WordWidth-1:0] word,
  output logic [Width-1:0]     data
);

  // Each operand bit belongs to exactly one word slot, so it only listens
  // for writes addressed to that slot.
  for (genvar i = 0; i < Width; i++) begin : g_bit
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data[i] <= 1'b0;
      end else if (we && (idx == CntW'(i / WordWidth))) begin
        data[i] <= word[i % WordWidth];
      end
    end
  end

endmodule

// File: rtl/mult_word_io.sv
// Word-serial loader/unloader around the Karatsuba accelerator: streams in A
// then B, pulses start, captures the product on done and streams it out.
module mult_word_io
  import mult_io_pkg::*;
#(
  parameter int BufferLength = BUFFER_LENGTH,
  parameter int InputALength = INPUT_A_LENGTH,
  parameter int InputBLength = INPUT_B_LENGTH,
  parameter int WordWidth    = WORD_WIDTH
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      in_valid_i,
  input  logic [WordWidth-1:0]      in_data_i,
  output logic                      in_ready_o,
  output logic [InputALength-1:0]   acc_inputA_o,
  output logic [InputBLength-1:0]   acc_inputB_o,
  output logic                      acc_start_o,
  input  logic                      acc_done_i,
  input  logic [2*BufferLength-1:0] acc_outputM_i,
  output logic                      out_valid_o,
  output logic [WordWidth-1:0]      out_data_o,
  output logic                      out_last_o,
  input  logic                      out_ready_i,
  output logic                      busy_o,
  output state_t                    dbg_state_o
);

  // Both streams use the same rule: a word moves on a rising edge where
  // valid and ready are both high; ready never depends on valid.
  localparam int Na    = ceil_div(InputALength, WordWidth);
  localparam int Nb    = ceil_div(InputBLength, WordWidth);
  localparam int Nm    = ceil_div(2 * BufferLength, WordWidth);
  localparam int CntW  = cnt_width(Na, Nb, Nm);
  localparam int ProdW = 2 * BufferLength;
  localparam int PadW  = Nm * WordWidth;

  state_t               state_q;
  logic [CntW-1:0]      cnt_q;
  logic [ProdW-1:0]     result_q;
  logic [PadW-1:0]      result_pad;
  logic [WordWidth-1:0] out_word;
  logic                 a_we;
  logic                 b_we;

  assign a_we = in_valid_i && (state_q == ST_LOAD_A);
  assign b_we = in_valid_i && (state_q == ST_LOAD_B);

  word_packer #(
    .Width    (InputALength),
    .WordWidth(WordWidth),
    .CntW     (CntW)
  ) u_pack_a (
    .clk  (clk_i),
    .rst_n(rst_ni),
    .we   (a_we),
    .idx  (cnt_q),
    .word (in_data_i),
    .data (acc_inputA_o)
  );

  word_packer #(
    .Width    (InputBLength),
    .WordWidth(WordWidth),
    .CntW     (CntW)
  ) u_pack_b (
    .clk  (clk_i),
    .rst_n(rst_ni),
    .we   (b_we),
    .idx  (cnt_q),
    .word (in_data_i),
    .data (acc_inputB_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_LOAD_A;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        ST_LOAD_A: begin
          if (in_valid_i) begin
            if (cnt_q == CntW'(Na - 1)) begin
              cnt_q   <= '0;
              state_q <= ST_LOAD_B;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        ST_LOAD_B: begin
          if (in_valid_i) begin
            if (cnt_q == CntW'(Nb - 1)) begin
              cnt_q   <= '0;
              state_q <= ST_START;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        ST_START: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (acc_done_i) begin
            result_q <= acc_outputM_i;
            cnt_q    <= '0;
            state_q  <= ST_UNLOAD;
          end
        end
        ST_UNLOAD: begin
          if (out_ready_i) begin
            if (cnt_q == CntW'(Nm - 1)) begin
              cnt_q   <= '0;
              state_q <= ST_LOAD_A;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= ST_LOAD_A;
        end
      endcase
    end
  end

  // Zero-extension supplies the fill above the product in the top word.
  assign result_pad = PadW'(result_q);

  always_comb begin
    out_word = '0;
    for (int j = 0; j < Nm; j++) begin
      if (cnt_q == CntW'(j)) out_word = result_pad[j*WordWidth +: WordWidth];
    end
  end

  assign in_ready_o  = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
  assign acc_start_o = (state_q == ST_START);
  assign out_valid_o = (state_q == ST_UNLOAD);
  assign out_data_o  = out_word;
  assign out_last_o  = out_valid_o && (cnt_q == CntW'(Nm - 1));
  assign busy_o      = !((state_q == ST_LOAD_A) && (cnt_q == '0));
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mult_word_io.sv
// Directed bench for mult_word_io: table of operand/product vectors plus
// hand-written reset, stall, spurious-done and back-to-back sequences.
module tb_mult_word_io;
  import mult_io_pkg::*;

  typedef struct packed {
    logic [4:0][31:0] a_w;
    logic [3:0][31:0] b_w;
    logic [130:0]     exp_a;
    logic [126:0]     exp_b;
    logic [263:0]     m;
    logic [8:0][31:0] exp_m;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [31:0]  in_data;
  logic         in_ready;
  logic [130:0] acc_a;
  logic [126:0] acc_b;
  logic         acc_start;
  logic         acc_done;
  logic [263:0] acc_m;
  logic         out_valid;
  logic [31:0]  out_data;
  logic         out_last;
  logic         out_ready;
  logic         busy;
  state_t       dbg_state;

  vec_t         vecs[4];
  logic [31:0]  exp_q[$];
  int           n_cmp;
  int           n_err;

  mult_word_io dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_valid_i   (in_valid),
    .in_data_i    (in_data),
    .in_ready_o   (in_ready),
    .acc_inputA_o (acc_a),
    .acc_inputB_o (acc_b),
    .acc_start_o  (acc_start),
    .acc_done_i   (acc_done),
    .acc_outputM_i(acc_m),
    .out_valid_o  (out_valid),
    .out_data_o   (out_data),
    .out_last_o   (out_last),
    .out_ready_i  (out_ready),
    .busy_o       (busy),
    .dbg_state_o  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 288'(in_ready), 288'(1));
    chk({tag, "_start"}, 288'(acc_start), 288'(0));
    chk({tag, "_out_valid"}, 288'(out_valid), 288'(0));
    chk({tag, "_out_last"}, 288'(out_last), 288'(0));
    chk({tag, "_out_data"}, 288'(out_data), 288'(0));
    chk({tag, "_busy"}, 288'(busy), 288'(0));
    chk({tag, "_acc_a"}, 288'(acc_a), 288'(0));
    chk({tag, "_acc_b"}, 288'(acc_b), 288'(0));
    chk({tag, "_state"}, 288'(dbg_state), 288'(ST_LOAD_A));
  endtask

  // Asynchronous reset in the middle of a cycle, checked before any clock edge.
  task automatic mid_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs(tag);
    in_valid  = 1'b0;
    acc_done  = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // driver: one full operation; abort_mode 1 = reset in WAIT, 2 = reset at output word 4
  task automatic run_op(input int v, input int ready_mode, input int done_lat,
                        input int abort_mode, input bit spurious, input bit b2b);
    int          j;
    int          hs;
    bit          rdy;
    bit          stalled;
    logic [31:0] prev_data;
    logic        prev_last;
    logic [31:0] e;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = vecs[v].a_w[k];
      chk("in_ready_a", 288'(in_ready), 288'(1));
      chk("busy_load_a", 288'(busy), 288'(k != 0));
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = vecs[v].b_w[k];
      acc_done = spurious && (k == 1);
      acc_m    = {264{1'b1}};
      chk("in_ready_b", 288'(in_ready), 288'(1));
      chk("start_in_load", 288'(acc_start), 288'(0));
    end
    @(negedge clk);
    in_valid = 1'b0;
    acc_done = 1'b0;
    chk("start_pulse", 288'(acc_start), 288'(1));
    chk("acc_a", 288'(acc_a), 288'(vecs[v].exp_a));
    chk("acc_b", 288'(acc_b), 288'(vecs[v].exp_b));
    chk("in_ready_start", 288'(in_ready), 288'(0));
    for (int c = 0; c < done_lat; c++) begin
      @(negedge clk);
      chk("start_wait", 288'(acc_start), 288'(0));
      chk("in_ready_wait", 288'(in_ready), 288'(0));
      chk("out_valid_wait", 288'(out_valid), 288'(0));
      if (abort_mode == 1 && c == 2) begin
        mid_reset("rst_wait");
        return;
      end
    end
    @(negedge clk);
    acc_done = 1'b1;
    acc_m    = vecs[v].m;
    @(negedge clk);
    acc_done = 1'b0;
    acc_m    = ~vecs[v].m;
    for (int k = 0; k < 9; k++) exp_q.push_back(vecs[v].exp_m[k]);
    j = 0;
    hs = 0;
    stalled = 1'b0;
    prev_data = '0;
    prev_last = 1'b0;
    for (int t = 0; t < 60 && j < 9; t++) begin
      if (t > 0) @(negedge clk);
      acc_done = 1'b0;
      if (abort_mode == 2 && j == 4) begin
        mid_reset("rst_unload");
        return;
      end
      if (spurious && j == 3) begin
        acc_done = 1'b1;
        acc_m    = {264{1'b1}};
      end
      rdy = (ready_mode == 0) ? 1'b1 : ((t % 3) == 0);
      out_ready = rdy;
      chk("out_valid", 288'(out_valid), 288'(1));
      if (stalled) begin
        chk("stall_data", 288'(out_data), 288'(prev_data));
        chk("stall_last", 288'(out_last), 288'(prev_last));
      end
      if (rdy) begin
        e = exp_q.pop_front();
        chk($sformatf("out_word%0d", j), 288'(out_data), 288'(e));
        chk($sformatf("out_last%0d", j), 288'(out_last), 288'(j == 8));
        j++;
        hs++;
        if (j == 9 && b2b) begin
          in_valid = 1'b1;
          in_data  = 32'hBAD0BAD0;
        end
      end
      stalled   = !rdy;
      prev_data = out_data;
      prev_last = out_last;
    end
    chk("unload_done", 288'(j), 288'(9));
    chk("handshakes", 288'(hs), 288'(9));
    if (!b2b) begin
      @(negedge clk);
      out_ready = 1'b0;
      acc_done  = 1'b0;
      chk("idle_out_valid", 288'(out_valid), 288'(0));
      chk("idle_in_ready", 288'(in_ready), 288'(1));
      chk("idle_busy", 288'(busy), 288'(0));
      chk("idle_last", 288'(out_last), 288'(0));
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    vecs[0].a_w   = {32'h0, 32'h0, 32'h0, 32'h0, 32'h1};
    vecs[0].b_w   = {32'h0, 32'h0, 32'h0, 32'h1};
    vecs[0].exp_a = 131'd1;
    vecs[0].exp_b = 127'd1;
    vecs[0].m     = 264'd1;
    vecs[0].exp_m = 288'd1;

    vecs[1].a_w   = {32'hFFFFFFFF, 128'h0};
    vecs[1].b_w   = {32'hFFFFFFFF, 96'h0};
    vecs[1].exp_a = {3'b111, 128'h0};
    vecs[1].exp_b = {31'h7FFFFFFF, 96'h0};
    vecs[1].m     = {264{1'b1}};
    vecs[1].exp_m = {32'h000000FF, {8{32'hFFFFFFFF}}};

    vecs[2].a_w   = {32'hFFFFFFFD, 32'hDEADBEEF, 32'h12345678, 32'hCAFEBABE, 32'h0BADF00D};
    vecs[2].b_w   = {32'h80000001, 32'h55AA55AA, 32'h0F0F0F0F, 32'h13579BDF};
    vecs[2].exp_a = {3'b101, 32'hDEADBEEF, 32'h12345678, 32'hCAFEBABE, 32'h0BADF00D};
    vecs[2].exp_b = {31'h00000001, 32'h55AA55AA, 32'h0F0F0F0F, 32'h13579BDF};
    vecs[2].m     = {8'h01, 256'h0};
    vecs[2].exp_m = {32'h00000001, 256'h0};

    vecs[3].a_w   = {32'h00000002, 32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
    vecs[3].b_w   = {32'h7FFFFFFF, 32'h0000000A, 32'h0000000B, 32'h0000000C};
    vecs[3].exp_a = {3'b010, 32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
    vecs[3].exp_b = {31'h7FFFFFFF, 32'h0000000A, 32'h0000000B, 32'h0000000C};
    vecs[3].m     = {8'hA5, 256'h0123456789ABCDEF_FEDCBA9876543210_0011223344556677_8899AABBCCDDEEFF};
    vecs[3].exp_m = {32'h000000A5, 32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210,
                     32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    acc_done  = 1'b0;
    acc_m     = '0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_reset_outputs("por");
    rst_n = 1'b1;

    for (int v = 0; v < 3; v++) begin
      run_op(v, (v == 2) ? 1 : 0, (v == 0) ? 10 : $urandom_range(1, 6), 0, v == 2, 1'b0);
    end
    run_op(0, 0, 4, 1, 1'b0, 1'b0);
    run_op(1, 0, 2, 2, 1'b0, 1'b0);
    run_op(3, 0, 4, 0, 1'b0, 1'b0);
    run_op(2, 0, 2, 0, 1'b0, 1'b1);
    run_op(3, 0, $urandom_range(1, 8), 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
